// File: rtl/led_pio_sequencer.sv
// led_pio_sequencer: steps a small table of LED patterns out to an Avalon-MM
// LED PIO. Software programs the patterns, the step period and CTRL.run through
// a zero-wait slave port. The block then writes each pattern to PIO address 0
// as an Avalon master, one-shot or looping, waiting the programmed interval
// between writes.
module led_pio_sequencer #(
    parameter int LED_WIDTH = 4,
    parameter int STEPS     = 4,
    parameter int PERIOD_W  = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    localparam int PAT_W  = LED_WIDTH * STEPS;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic                  run_q;
    logic                  loop_q;
    logic                  done_q;
    logic [PERIOD_W-1:0]   period_q;
    logic [PAT_W-1:0]      pattern_q;

    logic                  done_set;
    logic                  run_clr;
    logic                  busy;
    logic [LED_WIDTH-1:0]  step_pat;
    logic [PERIOD_W-1:0]   cnt_load;

    logic wr_en, wr_ctrl, wr_period, wr_pattern, wr_status;

    assign wr_en      = s_chipselect & ~s_write_n;
    assign wr_ctrl    = wr_en && (s_address == 2'd0);
    assign wr_period  = wr_en && (s_address == 2'd1);
    assign wr_pattern = wr_en && (s_address == 2'd2);
    assign wr_status  = wr_en && (s_address == 2'd3);

    assign busy      = (state_q != S_IDLE);
    // PATTERN is read live, so a rewrite while running shows up on the next write.
    assign step_pat  = pattern_q[int'(step_q) * LED_WIDTH +: LED_WIDTH];
    // A period of 0 behaves as 1; the counter counts down to 0 inclusive.
    assign cnt_load  = (period_q == '0) ? '0 : (period_q - PERIOD_W'(1));
    assign m_address = 2'b00;

    // Software-visible registers; a CTRL write beats the sequencer's own run clear,
    // and a done set beats a simultaneous done clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q     <= 1'b0;
            loop_q    <= 1'b0;
            done_q    <= 1'b0;
            period_q  <= '0;
            pattern_q <= '0;
        end else begin
            if (wr_ctrl) begin
                run_q  <= s_writedata[0];
                loop_q <= s_writedata[1];
            end else if (run_clr) begin
                run_q  <= 1'b0;
            end
            if (wr_period) begin
                period_q <= s_writedata[PERIOD_W-1:0];
            end
            if (wr_pattern) begin
                pattern_q <= s_writedata[PAT_W-1:0];
            end
            if (done_set) begin
                done_q <= 1'b1;
            end else if (wr_status && s_writedata[1]) begin
                done_q <= 1'b0;
            end
        end
    end

    // Sequencer state, step index and interval counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and master-port outputs; a started PIO write always finishes.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        done_set     = 1'b0;
        run_clr      = 1'b0;
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_writedata  = '0;
        case (state_q)
            S_IDLE: begin
                if (run_q) begin
                    step_d  = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_writedata  = 32'(step_pat);
                if (!m_waitrequest) begin
                    cnt_d = cnt_load;
                    if (run_q) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                        step_d  = '0;
                    end
                end
            end
            S_WAIT: begin
                if (!run_q) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else if (cnt_q == '0) begin
                    if (step_q != LAST_STEP) begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = S_WRITE;
                    end else if (loop_q) begin
                        step_d  = '0;
                        state_d = S_WRITE;
                    end else begin
                        done_set = 1'b1;
                        run_clr  = 1'b1;
                        step_d   = '0;
                        state_d  = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Register readback, combinational and side-effect free.
    always_comb begin
        s_readdata = '0;
        case (s_address)
            2'd0: s_readdata = {30'b0, loop_q, run_q};
            2'd1: s_readdata = 32'(period_q);
            2'd2: s_readdata = 32'(pattern_q);
            2'd3: s_readdata = {22'b0, 8'(step_q), done_q, busy};
            default: s_readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Testbench for led_pio_sequencer: expected PIO writes (data and acceptance
// cycle) are queued from a simple timing model; a monitor pops and compares
// every accepted master write.
module tb_led_pio_sequencer;

    localparam int STEPS = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;
    exp_t expq[$];

    led_pio_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_chipselect  (s_chipselect),
        .s_write_n     (s_write_n),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted PIO write must match the head of the queue.
    always @(negedge clk) begin : mon
        exp_t e;
        #1;
        if (reset_n && m_chipselect && !m_write_n && !m_waitrequest) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got data 0x%0h at cycle %0d, expected no write",
                         m_writedata, cyc);
            end else begin
                e = expq.pop_front();
                chk("pio_data", m_writedata, e.data);
                chk("pio_cycle", cyc, e.cyc);
                chk("pio_addr", 32'(m_address), 32'd0);
            end
        end
    end

    // Reference: first accept at 'start'; each later write follows the previous
    // acceptance by max(period,1)+1 cycles; an optional stall delays one step.
    task automatic push_run(input int start, input logic [15:0] pat, input int period,
                            input int nwrites, input int stall_step, input int stall_len);
        exp_t e;
        int p = (period < 1) ? 1 : period;
        int t = start;
        for (int i = 0; i < nwrites; i++) begin
            if (i == stall_step) t += stall_len;
            e.cyc  = t;
            e.data = 32'(pat[(i % STEPS) * 4 +: 4]);
            expq.push_back(e);
            t += p + 1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int ecyc);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(negedge clk);
        ecyc         = cyc;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        s_address = a;
        #1;
        d = s_readdata;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] st;
        int n = 0;
        repeat (2) @(negedge clk);
        rd(2'd3, st);
        while (st[0] && n < budget) begin
            @(negedge clk);
            rd(2'd3, st);
            n++;
        end
        chk("wait_idle_busy", 32'(st[0]), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] d;
        int k, w;
        logic [15:0] pat;
        int per;

        reset_n       = 1'b0;
        s_address     = 2'd0;
        s_chipselect  = 1'b0;
        s_write_n     = 1'b1;
        s_writedata   = '0;
        m_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset values
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            chk("reset_reg", d, 32'd0);
        end
        chk("reset_cs", 32'(m_chipselect), 32'd0);
        chk("reset_wn", 32'(m_write_n), 32'd1);
        chk("reset_wd", m_writedata, 32'd0);

        // Asynchronous reset while a write is stalled
        @(negedge clk);
        wr(2'd2, 32'h8421, w);
        m_waitrequest = 1'b1;
        wr(2'd0, 32'h1, k);
        wait_until(k + 1);
        #1;
        chk("arst_pre_cs", 32'(m_chipselect), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_cs", 32'(m_chipselect), 32'd0);
        chk("arst_wn", 32'(m_write_n), 32'd1);
        rd(2'd3, d);
        chk("arst_status", d, 32'd0);
        rd(2'd2, d);
        chk("arst_pattern", d, 32'd0);
        @(negedge clk);
        reset_n       = 1'b1;
        m_waitrequest = 1'b0;
        @(negedge clk);

        // One-shot, PERIOD=3
        wr(2'd2, 32'h8421, w);
        wr(2'd1, 32'd3, w);
        wr(2'd0, 32'h1, k);
        push_run(k + 1, 16'h8421, 3, 4, -1, 0);
        wait_idle(100);
        chk("oneshot_all_writes", 32'(expq.size()), 32'd0);
        rd(2'd3, d);
        chk("oneshot_status", d, 32'h2);
        rd(2'd0, d);
        chk("oneshot_ctrl", d, 32'h0);

        // Done clear, then looping run stopped from WAIT
        wr(2'd3, 32'h2, w);
        rd(2'd3, d);
        chk("done_clear", d, 32'h0);
        wr(2'd0, 32'h3, k);
        push_run(k + 1, 16'h8421, 3, 5, -1, 0);
        wait_until(k + 18);
        wr(2'd0, 32'h2, w);
        @(negedge clk);
        rd(2'd3, d);
        chk("loop_stop_status", d, 32'h0);
        repeat (12) @(negedge clk);
        chk("loop_stop_queue", 32'(expq.size()), 32'd0);

        // PERIOD=0 with a 5-cycle stall on step 1
        wr(2'd1, 32'd0, w);
        wr(2'd0, 32'h1, k);
        push_run(k + 1, 16'h8421, 0, 4, 1, 5);
        wait_until(k + 3);
        m_waitrequest = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("stall_data", m_writedata, 32'h2);
            chk("stall_strobe", 32'(m_chipselect & ~m_write_n), 32'd1);
            @(negedge clk);
        end
        m_waitrequest = 1'b0;
        wait_idle(100);
        chk("stall_all_writes", 32'(expq.size()), 32'd0);
        rd(2'd3, d);
        chk("stall_status", d, 32'h2);
        wr(2'd3, 32'h2, w);

        // run cleared while WRITE is stalled: transfer still completes
        wr(2'd1, 32'd2, w);
        m_waitrequest = 1'b1;
        wr(2'd0, 32'h1, k);
        push_run(k + 4, 16'h8421, 2, 1, -1, 0);
        wait_until(k + 2);
        wr(2'd0, 32'h0, w);
        #1;
        chk("runclr_hold_cs", 32'(m_chipselect), 32'd1);
        @(negedge clk);
        m_waitrequest = 1'b0;
        @(negedge clk);
        rd(2'd3, d);
        chk("runclr_status", d, 32'h0);
        repeat (8) @(negedge clk);
        chk("runclr_queue", 32'(expq.size()), 32'd0);

        // Done-clear on the same edge as done set: set wins
        wr(2'd1, 32'd3, w);
        wr(2'd0, 32'h1, k);
        push_run(k + 1, 16'h8421, 3, 4, -1, 0);
        wait_until(k + 16);
        wr(2'd3, 32'h2, w);
        rd(2'd3, d);
        chk("done_set_wins", d, 32'h2);
        chk("done_race_queue", 32'(expq.size()), 32'd0);
        wr(2'd3, 32'h2, w);
        rd(2'd3, d);
        chk("done_clear2", d, 32'h0);

        // Randomized one-shot runs
        for (int r = 0; r < 8; r++) begin
            pat = 16'($urandom);
            per = int'($urandom_range(0, 6));
            wr(2'd2, 32'(pat), w);
            wr(2'd1, 32'(per), w);
            rd(2'd1, d);
            chk("rand_period_rb", d, 32'(per));
            rd(2'd2, d);
            chk("rand_pattern_rb", d, 32'(pat));
            wr(2'd0, 32'h1, k);
            push_run(k + 1, pat, per, 4, -1, 0);
            wait_idle(200);
            chk("rand_all_writes", 32'(expq.size()), 32'd0);
            rd(2'd3, d);
            chk("rand_status", d, 32'h2);
            wr(2'd3, 32'h2, w);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
